// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for uart_rx (and uart_tx going forward).
//   OVERSAMPLE_DEFAULT : clk ticks per serial bit
//   DATA_BITS_DEFAULT  : data bits per frame
//   IDLE_LEVEL         : level of an idle serial line
//   rx_state_t         : receiver FSM states
//   maj3()             : 2-of-3 majority helper
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   OVERSAMPLE_DEFAULT = 16;
    localparam int   DATA_BITS_DEFAULT  = 8;
    localparam logic IDLE_LEVEL         = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Serial input and parallel result signals of the UART receiver.
//   bit_in        : raw serial line (driven by the line source)
//   data_received : last received word, held until the next frame completes
//   received      : one-cycle pulse, good frame
//   framing_err   : one-cycle pulse, stop bit sampled low
//   busy          : receiver is inside a frame (or waiting out a break)
// Modports:
//   master : line source / result consumer
//   slave  : the receiver
// ----------------------------------------------------------------------------
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) ();

    logic                 bit_in;
    logic [DATA_BITS-1:0] data_received;
    logic                 received;
    logic                 framing_err;
    logic                 busy;

    modport master (
        output bit_in,
        input  data_received,
        input  received,
        input  framing_err,
        input  busy
    );

    modport slave (
        input  bit_in,
        output data_received,
        output received,
        output framing_err,
        output busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// 2-FF synchroniser for the asynchronous serial line, reset to the idle level.
// Optional macro UART_RX_MAJORITY_EN: adds a sample history so that rx_sample
// is the 2-of-3 majority of rx_s over the current and two previous cycles.
// Without the macro rx_sample is simply rx_s.
// Ports:
//   clk       : baud x16 tick clock
//   rst_n     : asynchronous active-low reset
//   bit_in    : raw serial line
//   rx_s      : synchronised line (2-cycle latency)
//   rx_sample : value used at the FSM sample points
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    output logic rx_s,
    output logic rx_sample
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], bit_in};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Three-deep history is {hist_q[1], hist_q[0], rx_s}: the newest entry is
    // the synchroniser output itself, so the vote adds no latency and the
    // sample points stay where they are without majority.
    logic [1:0] hist_q;
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= {2{IDLE_LEVEL}};
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign hist      = {hist_q, rx_s};
    assign rx_sample = maj3(hist[2], hist[1], hist[0]);
`else
    assign rx_sample = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 16x-oversampled 8N1 UART receiver (LSB first, idle high). Delivers each
// frame as a parallel word with a one-cycle strobe; a low stop bit gives a
// framing_err strobe and the receiver then waits for the line to go high
// before it will look for another start bit.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority voting at every sample
// point (see uart_rx_sync).
// Parameters:
//   OVERSAMPLE : clk ticks per bit, even and >= 8
//   DATA_BITS  : data bits per frame
// Ports:
//   clk   : baud x16 tick clock
//   rst_n : asynchronous active-low reset
//   rx    : uart_rx_if.slave (bit_in, data_received, received,
//           framing_err, busy)
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TICK_W-1:0]    tick;
    logic [TICK_W-1:0]    tick_inc;
    logic                 tick_at_last;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_q;
    logic                 received_q;
    logic                 framing_err_q;
    logic                 busy_q;
    logic                 rx_s;
    logic                 rx_sample;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (rx.bit_in),
        .rx_s      (rx_s),
        .rx_sample (rx_sample)
    );

    // Explicit wrap so a non-power-of-two OVERSAMPLE still counts 0..N-1.
    assign tick_at_last = (tick == TICK_LAST);
    assign tick_inc     = tick_at_last ? '0 : tick + TICK_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tick          <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_q        <= '0;
            received_q    <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            received_q    <= 1'b0;
            framing_err_q <= 1'b0;

            case (state)
                IDLE: begin
                    tick <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end

                // Half-bit wait: from here on every sample lands one full
                // bit later, i.e. at the centre of each following bit.
                START: begin
                    if (tick == TICK_MID) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        if (rx_sample) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end

                DATA: begin
                    tick <= tick_inc;
                    if (tick_at_last) begin
                        shift_reg <= {rx_sample, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end

                // Leaving at mid-stop lets a start edge right at the end of
                // the stop bit be caught (back-to-back frames).
                STOP: begin
                    tick <= tick_inc;
                    if (tick_at_last) begin
                        data_q <= shift_reg;
                        if (rx_sample) begin
                            received_q <= 1'b1;
                            state      <= IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            framing_err_q <= 1'b1;
                            state         <= BREAK_WAIT;
                        end
                    end
                end

                // Stay here while the line is low so a break is not decoded
                // as a stream of zero frames.
                BREAK_WAIT: begin
                    tick <= tick_inc;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tick   <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.data_received = data_q;
    assign rx.received      = received_q;
    assign rx.framing_err   = framing_err_q;
    assign rx.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames into uart_rx; a reference model derives the expected
// word / frame status from the line waveform (sampled at bit centres, with
// 2-of-3 voting when UART_RX_MAJORITY_EN is defined) and queues it; a monitor
// pops and compares on every received / framing_err pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS    = 16;
    localparam int DB    = 8;
    localparam int FRAME = OS * (DB + 2);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks    = 0;
    int         failures  = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;
    logic [7:0] model_last = 8'h00;
    bit         fw [FRAME];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit line_sample(input int p);
`ifdef UART_RX_MAJORITY_EN
        int ones;
        ones = int'(fw[p-2]) + int'(fw[p-1]) + int'(fw[p]);
        return ones >= 2;
`else
        return fw[p];
`endif
    endfunction

    function automatic void build_frame(input logic [7:0] d, input bit stop_lvl, input int glitch);
        for (int i = 0; i < FRAME; i++) begin
            if (i < OS)                 fw[i] = 1'b0;
            else if (i < OS * (DB + 1)) fw[i] = d[i / OS - 1];
            else                        fw[i] = stop_lvl;
        end
        if (glitch >= 0 && glitch < FRAME) fw[glitch] = ~fw[glitch];
    endfunction

    // Start checked at half a bit, data and stop at the centre of each bit.
    function automatic void model_frame();
        exp_t       e;
        logic [7:0] b;
        if (line_sample(OS / 2)) return;
        for (int k = 0; k < DB; k++) b[k] = line_sample(OS * (k + 1) + OS / 2);
        e.data = b;
        e.ferr = !line_sample(OS * (DB + 1) + OS / 2);
        sb.push_back(e);
        model_last = b;
    endfunction

    // ---------------- stimulus helpers (called just after a posedge) -------
    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            bus.bit_in = fw[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        bus.bit_in = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (bus.received || bus.framing_err)) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.received, bus.framing_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, bus.received, bus.framing_err},
                      {30'd0, !e.ferr, e.ferr});
                check("rx_byte", {24'd0, bus.data_received}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0, lat, pc0, w;
        bus.bit_in = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, bus.data_received}, 32'd0);
        check("rst_recv",  {31'd0, bus.received},      32'd0);
        check("rst_ferr",  {31'd0, bus.framing_err},   32'd0);
        check("rst_busy",  {31'd0, bus.busy},          32'd0);
        rst_n = 1'b1;
        idle(10);

        // Loopback-style frame 0xA5
        pc0 = pulse_cnt;
        build_frame(8'hA5, 1'b1, -1); model_frame(); play(FRAME);
        check("a5_pulses", pulse_cnt - pc0, 1);
        check("a5_data",   {24'd0, bus.data_received}, 32'hA5);
        check("a5_busy_after", {31'd0, bus.busy}, 32'd0);
        idle(5);

        // Latency of frame 0x3C
        build_frame(8'h3C, 1'b1, -1); model_frame();
        t0 = cyc + 1;
        play(FRAME);
        lat = last_pulse_cyc - t0;
        check("3c_latency_window", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        check("3c_data", {24'd0, bus.data_received}, 32'h3C);
        idle(5);

        // 4-cycle low glitch on an idle line
        pc0 = pulse_cnt;
        for (int i = 0; i < FRAME; i++) fw[i] = (i >= 4);
        model_frame();
        play(12);
        check("glitch_busy_cleared", {31'd0, bus.busy}, 32'd0);
        check("glitch_data_held", {24'd0, bus.data_received}, {24'd0, model_last});
        idle(20);
        check("glitch_no_pulse", pulse_cnt - pc0, 0);

        // 0x81 with low stop bit, then line held low for 50 bit times
        pc0 = pulse_cnt;
        build_frame(8'h81, 1'b0, -1); model_frame(); play(FRAME);
        check("brk_data", {24'd0, bus.data_received}, 32'h81);
        bus.bit_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            repeat (200) begin @(posedge clk); #1; end
            check("brk_busy_held", {31'd0, bus.busy}, 32'd1);
        end
        check("brk_one_pulse", pulse_cnt - pc0, 1);
        bus.bit_in = 1'b1;
        w = 0;
        while (bus.busy && w < 8) begin @(posedge clk); #1; w++; end
        check("brk_release", {31'd0, bus.busy}, 32'd0);
        idle(20);
        check("brk_no_more_pulses", pulse_cnt - pc0, 1);

        // Back-to-back 0x00, 0xFF, then reset in the middle of a third frame
        pc0 = pulse_cnt;
        build_frame(8'h00, 1'b1, -1); model_frame(); play(FRAME);
        build_frame(8'hFF, 1'b1, -1); model_frame(); play(FRAME);
        check("b2b_pulses", pulse_cnt - pc0, 2);
        build_frame(8'hC3, 1'b1, -1); play(80);
        rst_n      = 1'b0;
        bus.bit_in = 1'b1;
        #2;
        check("mid_rst_data", {24'd0, bus.data_received}, 32'd0);
        check("mid_rst_recv", {31'd0, bus.received},      32'd0);
        check("mid_rst_ferr", {31'd0, bus.framing_err},   32'd0);
        check("mid_rst_busy", {31'd0, bus.busy},          32'd0);
        model_last = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        check("mid_rst_no_pulse", pulse_cnt - pc0, 2);
        build_frame(8'h5A, 1'b1, -1); model_frame(); play(FRAME);
        check("post_rst_data", {24'd0, bus.data_received}, 32'h5A);
        idle(5);

        // Single-cycle inverted glitch at the centre of data bit 3 of 0x00
        build_frame(8'h00, 1'b1, OS * 4 + OS / 2); model_frame(); play(FRAME);
        check("centre_glitch_data", {24'd0, bus.data_received}, {24'd0, GLITCH_EXP});
        idle(5);

        // Randomised frames: random data, gaps, near-centre glitches, bad stops
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            int  g;
            bit  bad;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 99) < 15);
            g   = -1;
            if ($urandom_range(0, 3) == 0)
                g = OS * (int'($urandom_range(0, DB - 1)) + 1) + OS / 2 + int'($urandom_range(0, 4)) - 3;
            idle($urandom_range(0, 24));
            build_frame(d, !bad, g); model_frame(); play(FRAME);
            if (bad) begin
                bus.bit_in = 1'b0;
                repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
                idle(10);
            end
        end
        idle(30);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampled UART receiver; the downstream peer of the team's uart_tx.
- Consumes the serial line (8N1, LSB first, one bit = OVERSAMPLE clk ticks, idle high) and delivers each byte as a parallel word with a one-cycle strobe.
- Runs on the same baud-x16 tick clock as uart_tx, so a uart_tx bit_out can be looped straight into bit_in.

Parameters:
- OVERSAMPLE, 16, clk ticks per bit; must be at least 8 and even.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  in  1  baud x16 tick clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  raw serial line; asynchronous to clk.
- data_received  out  DATA_BITS  last received byte; held until the next frame completes.
- received  out  1  one-cycle pulse: data_received is valid and the stop bit was good.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low, async):
  - Outputs: data_received=0, received=0, framing_err=0, busy=0.
  - Internal: state=IDLE, tick and bit counters = 0, synchroniser flops = 1.
  - Reset mid-frame aborts the frame silently, with no pulse.
- Input path:
  - bit_in passes through a 2-FF synchroniser to give rx_s (2-cycle latency).
  - All decisions use rx_s.
- tick: counter 0..OVERSAMPLE-1, wraps, runs in every state except IDLE.
- Mid-bit sample point: tick == OVERSAMPLE-1 in DATA/STOP; tick == OVERSAMPLE/2-1 in START.
- States:
  - IDLE: when rx_s==0, go to START with tick=0 and busy=1.
  - START: at the mid sample:
    - sample 1 (false start / glitch): return to IDLE, no output.
    - sample 0: go to DATA with tick=0, bit_idx=0. From here every sample falls one full bit later, at the centre of each data bit.
  - DATA: at each sample, shift into a shift register LSB first (bit_idx 0 is the first bit received). After bit DATA_BITS-1, go to STOP with tick=0.
  - STOP: at the sample:
    - rx_s==1: data_received <= shift register; received=1 for one cycle; go to IDLE.
    - rx_s==0: data_received <= shift register anyway; framing_err=1 for one cycle; received stays 0; go to BREAK_WAIT.
  - BREAK_WAIT: hold busy=1 until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from being decoded as repeated 0x00 frames.
- Early return: IDLE is re-entered at mid-stop, half a bit early. A start edge arriving at or after that point is accepted, so back-to-back frames with no extra idle are received.
- Latency: received asserts 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE cycles (±1) after the raw falling edge of the start bit. With the defaults that is 154 cycles.
- Pulses: received and framing_err are never high together. Both are registered outputs.
- Counters: tick is $clog2(OVERSAMPLE) bits wide and bit_idx is $clog2(DATA_BITS) bits wide. There is no overflow path; both wrap or clear explicitly.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample is the 2-of-3 majority of rx_s at sample point-2, point-1 and point. This applies to the start check, data bits and stop bit. A single-cycle glitch at mid-bit is rejected. Sample points and latency are unchanged.
- Undefined: a single sample of rx_s at the sample point; no majority logic is instantiated.

Decomposition:
- Package uart_pkg:
  - Constants: OVERSAMPLE_DEFAULT=16, DATA_BITS_DEFAULT=8, IDLE_LEVEL=1'b1.
  - Typedef: rx_state_t with IDLE, START, DATA, STOP, BREAK_WAIT.
  - Shared with uart_tx for future alignment.
- One sub-module, uart_rx_sync:
  - 2-FF synchroniser with reset value 1.
  - With UART_RX_MAJORITY_EN, also a 3-deep history register and the majority output.
  - Top-level uart_rx holds the FSM, counters and shift register.

Test Plan:
- Loopback a uart_tx instance sending 0xA5 into bit_in -> received pulses exactly once; data_received=0xA5; framing_err stays 0; busy falls after the pulse.
- Direct frame 0x3C, start falling edge at cycle t0 -> received high only at t0+154 (±1); data_received=0x3C.
- Low glitch of 4 cycles on an idle line -> back to IDLE by glitch start +12; no pulse; data_received unchanged.
- Frame 0x81 with stop bit driven low, line then held low for 50 bit times -> one framing_err pulse; data_received=0x81; received=0; busy stays 1 until the line rises; no further pulses.
- Back-to-back frames 0x00 then 0xFF with zero extra idle, then rst_n pulsed low mid-way through a third frame -> two received pulses with the correct bytes. After reset all outputs are 0, no pulse for the aborted frame, and the next clean frame 0x5A is received correctly.
- Macro defined vs undefined, 1-cycle inverted glitch at the centre tick of data bit 3 of 0x00 -> defined: data_received=0x00; undefined: data_received=0x08.
